cordic_twiddle_ctrl: RTL
========================

# cordic_twiddle_ctrl

Sequencer that drives the shared twiddle CORDIC pipeline to produce a programmed run of twiddle factors exp(j·θk), θk = phase0 + k·step. The CORDIC pipeline cannot stall, so this block tracks in-flight samples and only issues when space is guaranteed. It captures results into an internal FIFO and presents them to the FFT butterfly as a ready/valid stream. It sits between the FFT stage controller (config/start) and the twiddle CORDIC instance, a sibling block wired through the cordic_* ports.

## Interface
- WIDTH, 16, CORDIC data width; also CORDIC latency in cycles
- W_ANGLE, 20, angle width; 2^W_ANGLE = 360°, top two bits = quadrant
- FIFO_DEPTH, 32, result FIFO entries; must be ≥ WIDTH+2 for full throughput
- CNT_W, 16, width of run-length counter

- clock  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; starts a run when idle
- cfg_count  in  CNT_W  twiddles in run; 0 = empty run
- cfg_phase0  in  W_ANGLE  first angle
- cfg_step  in  W_ANGLE  angle increment, modulo 2^W_ANGLE
- cfg_amp  in  WIDTH  x_start magnitude (pre-scaled by 1/K)
- cordic_x_start, cordic_y_start  out  WIDTH  to CORDIC; y_start always 0
- cordic_angle  out  W_ANGLE  to CORDIC
- cordic_cos, cordic_sin  in  WIDTH  from CORDIC
- tw_valid  out  1  stream valid
- tw_ready  in  1  stream ready
- tw_re, tw_im  out  WIDTH  twiddle real/imag (= cos, sin)
- tw_last  out  1  marks final twiddle of run
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse at run end

## Operation
- FSM IDLE/RUN/DRAIN; reset → IDLE.
- IDLE: on start, latch cfg_* and zero the issue counter.
  - cfg_count=0 → stay IDLE; done pulses next cycle; no stream output.
  - Otherwise → RUN.
- start outside IDLE is ignored. cfg_* changes after acceptance have no effect.
- RUN: issue in a cycle iff fifo_cnt + inflight < FIFO_DEPTH, using registered counts; pops in that cycle are not credited.
  - Issue presents cordic_angle = phase accumulator; the accumulator then adds step, wrapping naturally modulo 2^W_ANGLE.
  - Issue of item cfg_count−1 → DRAIN.
- Valid/last tracking: a WIDTH-deep shift register carries issue and last flags. A flag exiting the register writes cordic_cos/sin plus the last flag into the FIFO that cycle.
- inflight: +1 on issue, −1 on FIFO write; both in one cycle → unchanged.
- FIFO: pop on tw_valid & tw_ready. Simultaneous push and pop is legal. Write never occurs when full; this is guaranteed by the credit rule. Order is preserved.
- DRAIN: on pop of the last-flagged entry → IDLE; done pulses the following cycle and busy drops with it.
- cordic_angle and cordic_x_start are held at their last value when not issuing. Non-issue CORDIC outputs are ignored.

## Timing
- Reset values: tw_valid=0, tw_last=0, tw_re=tw_im=0, busy=0, done=0, cordic_angle=0, cordic_x_start=0, cordic_y_start=0. FIFO and inflight are cleared, and the shift register is all zero.
- Reset asserted mid-run aborts immediately and asynchronously. No partial output appears after release.
- start is sampled at edge E0.
  - busy is high from cycle E0+1.
  - First issue is in cycle E0+1.
  - Its CORDIC result is present in cycle E0+1+WIDTH and written at the end of that cycle.
  - tw_valid first asserts in cycle E0+2+WIDTH (18 for WIDTH=16).
- Throughput: 1 twiddle/cycle with tw_ready held high and FIFO_DEPTH ≥ WIDTH+2.
- tw_re, tw_im and tw_last are stable while tw_valid=1 and tw_ready=0.

## Test plan
- Reset: hold rst_n=0, toggle start → all outputs at reset values, no issue; release rst_n → still idle.
- Quadrants: count=4, phase0=0, step=0x40000, amp=9949, tw_ready=1 → (16384,0), (0,16384), (−16384,0), (0,−16384) ±4 LSB. First tw_valid at cycle 18 after start, tw_last on 4th, done one cycle after 4th pop.
- Wrap: phase0=0xC0000, step=0x40000, count=3 → angles 270°, 0°, 90°; outputs (0,−16384), (16384,0), (0,16384) ±4.
- Backpressure: count=64, tw_ready=0 → issues stop at fifo_cnt+inflight=32, no overflow. Raise tw_ready with random toggling → 64 outputs in phase order, single tw_last.
- Ignored inputs: start pulsed and cfg_* changed mid-run → run unaffected. count=0 start → done pulse next cycle, tw_valid never high.
- Abort: rst_n low at cycle 10 of a 20-item run → outputs zero immediately. A new count=2 run after release yields exactly 2 correct twiddles.

Source files
------------

// File: rtl/cordic_twiddle_ctrl.sv
// Twiddle sequencer: issues phase-stepped angles into a fixed-latency CORDIC,
// tracks in-flight work with credits and streams results out through a FIFO.
module cordic_twiddle_ctrl #(
  parameter int WIDTH      = 16,
  parameter int W_ANGLE    = 20,
  parameter int FIFO_DEPTH = 32,
  parameter int CNT_W      = 16
) (
  input  logic               clock,
  input  logic               rst_n,
  input  logic               start,
  input  logic [CNT_W-1:0]   cfg_count,
  input  logic [W_ANGLE-1:0] cfg_phase0,
  input  logic [W_ANGLE-1:0] cfg_step,
  input  logic [WIDTH-1:0]   cfg_amp,
  output logic [WIDTH-1:0]   cordic_x_start,
  output logic [WIDTH-1:0]   cordic_y_start,
  output logic [W_ANGLE-1:0] cordic_angle,
  input  logic [WIDTH-1:0]   cordic_cos,
  input  logic [WIDTH-1:0]   cordic_sin,
  output logic               tw_valid,
  input  logic               tw_ready,
  output logic [WIDTH-1:0]   tw_re,
  output logic [WIDTH-1:0]   tw_im,
  output logic               tw_last,
  output logic               busy,
  output logic               done
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int OCC_W = PTR_W + 1;
  localparam int ENT_W = 2 * WIDTH + 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [CNT_W-1:0]   issue_cnt_q, issue_cnt_d;
  logic [W_ANGLE-1:0] step_q, step_d;
  logic [W_ANGLE-1:0] phase_q, phase_d;
  logic [WIDTH-1:0]   amp_q, amp_d;
  logic [W_ANGLE-1:0] angle_q, angle_d;
  logic [WIDTH-1:0]   xs_q, xs_d;
  logic [WIDTH-1:0]   vld_sr_q, vld_sr_d;
  logic [WIDTH-1:0]   last_sr_q, last_sr_d;
  logic [OCC_W-1:0]   inflight_q, inflight_d;
  logic [OCC_W-1:0]   fifo_cnt_q, fifo_cnt_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic               done_q, done_d;

  logic [ENT_W-1:0]   mem [FIFO_DEPTH];
  logic [ENT_W-1:0]   rd_entry;
  logic [OCC_W:0]     occ;
  logic               issue, is_last, push, pop;

  // Credits use registered counts only, so a pop this cycle frees no slot yet.
  assign occ      = {1'b0, fifo_cnt_q} + {1'b0, inflight_q};
  assign issue    = (state_q == RUN) && (occ < (OCC_W + 1)'(FIFO_DEPTH));
  assign is_last  = (issue_cnt_q == count_q - CNT_W'(1));
  assign push     = vld_sr_q[WIDTH-1];
  assign tw_valid = (fifo_cnt_q != '0);
  assign pop      = tw_valid && tw_ready;
  assign rd_entry = mem[rd_ptr_q];

  assign tw_re          = tw_valid ? rd_entry[WIDTH-1:0] : '0;
  assign tw_im          = tw_valid ? rd_entry[2*WIDTH-1:WIDTH] : '0;
  assign tw_last        = tw_valid ? rd_entry[ENT_W-1] : 1'b0;
  assign cordic_angle   = issue ? phase_q : angle_q;
  assign cordic_x_start = issue ? amp_q : xs_q;
  assign cordic_y_start = '0;
  assign busy           = (state_q != IDLE);
  assign done           = done_q;

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    issue_cnt_d = issue_cnt_q;
    step_d      = step_q;
    phase_d     = phase_q;
    amp_d       = amp_q;
    angle_d     = cordic_angle;
    xs_d        = cordic_x_start;
    vld_sr_d    = {vld_sr_q[WIDTH-2:0], issue};
    last_sr_d   = {last_sr_q[WIDTH-2:0], issue && is_last};
    inflight_d  = inflight_q;
    fifo_cnt_d  = fifo_cnt_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    done_d      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          count_d     = cfg_count;
          step_d      = cfg_step;
          phase_d     = cfg_phase0;
          amp_d       = cfg_amp;
          issue_cnt_d = '0;
          if (cfg_count == '0) done_d = 1'b1;
          else                 state_d = RUN;
        end
      end
      RUN: begin
        if (issue) begin
          phase_d     = phase_q + step_q;
          issue_cnt_d = issue_cnt_q + CNT_W'(1);
          if (is_last) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (pop && tw_last) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (issue && !push)      inflight_d = inflight_q + OCC_W'(1);
    else if (!issue && push) inflight_d = inflight_q - OCC_W'(1);

    if (push && !pop)      fifo_cnt_d = fifo_cnt_q + OCC_W'(1);
    else if (!push && pop) fifo_cnt_d = fifo_cnt_q - OCC_W'(1);

    if (push) wr_ptr_d = (wr_ptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = (rd_ptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      count_q     <= '0;
      issue_cnt_q <= '0;
      step_q      <= '0;
      phase_q     <= '0;
      amp_q       <= '0;
      angle_q     <= '0;
      xs_q        <= '0;
      vld_sr_q    <= '0;
      last_sr_q   <= '0;
      inflight_q  <= '0;
      fifo_cnt_q  <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      issue_cnt_q <= issue_cnt_d;
      step_q      <= step_d;
      phase_q     <= phase_d;
      amp_q       <= amp_d;
      angle_q     <= angle_d;
      xs_q        <= xs_d;
      vld_sr_q    <= vld_sr_d;
      last_sr_q   <= last_sr_d;
      inflight_q  <= inflight_d;
      fifo_cnt_q  <= fifo_cnt_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      done_q      <= done_d;
    end
  end

  // Storage needs no reset: every read is masked by tw_valid.
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr_q] <= {last_sr_q[WIDTH-1], cordic_sin, cordic_cos};
  end

endmodule
